// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared constants and types for the register file and its
//            per-port forwarding mux.
// Contents : DATA_W, ADDR_W  - default data / address widths
//            ZERO_REG        - index of the hard-wired zero register
//            CNT_W           - width of the committed-write counter
//            RegBus, RegAddrBus, cnt_t - convenience types
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 0;
  localparam int CNT_W    = 16;
  localparam int REG_NUM  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] RegBus;
  typedef logic [ADDR_W-1:0] RegAddrBus;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bypass
// Purpose  : Read-side forwarding mux for one register-file read port.
//            Selects, in falling priority: reset, disabled port, zero
//            register, EX result, MEM result, writeback data, array entry.
// Ports    : rst        in   active-low reset (forces data to zero)
//            re         in   read-port enable
//            raddr      in   read address
//            ex_*       in   EX-stage write flag / destination / data
//            mem_*      in   MEM-stage write flag / destination / data
//            we/waddr/wdata in writeback port (write-through source)
//            array_data in   entry read from the storage array
//            rdata      out  selected read data (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ex_wreg,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] array_data,
  output logic [DATA_W-1:0] rdata
);

  logic is_zero;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign is_zero = (raddr == ADDR_W'(ZERO_REG));
  assign ex_hit  = ex_wreg  && (ex_wd  == raddr);
  assign mem_hit = mem_wreg && (mem_wd == raddr);
  assign wb_hit  = we       && (waddr  == raddr);

  // Youngest pipeline result wins: EX is newer than MEM, MEM newer than WB.
  always_comb begin
    rdata = '0;
    if (!rst || !re || is_zero) begin
      rdata = '0;
    end else if (ex_hit) begin
      rdata = ex_wdata;
    end else if (mem_hit) begin
      rdata = mem_wdata;
    end else if (wb_hit) begin
      rdata = wdata;
    end else begin
      rdata = array_data;
    end
  end

endmodule : regfile_bypass
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Purpose  : 2-read / 1-write register file with EX/MEM/WB forwarding,
//            hard-wired zero register and a committed-write counter.
// Ports    : clk                 in   clock, array updates on rising edge
//            rst                 in   asynchronous active-low reset
//            we/waddr/wdata      in   writeback port
//            re1/raddr1/rdata1   read port 1 (rdata combinational)
//            re2/raddr2/rdata2   read port 2 (rdata combinational)
//            ex_wreg_i/ex_wd_i/ex_wdata_i    EX-stage forwarding source
//            mem_wreg_i/mem_wd_i/mem_wdata_i MEM-stage forwarding source
//            wr_cnt              out  committed array writes, mod 2**16
// Revision : 1.0 - initial release
// ============================================================================
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              ex_wreg_i,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              mem_wreg_i,
  input  logic [ADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [REGS];
  logic [CNT_W-1:0]  cnt_q;
  logic              armed_q;
  logic              commit;
  logic [DATA_W-1:0] array_rd1;
  logic [DATA_W-1:0] array_rd2;

  // armed_q stays low until one full clock edge has passed with reset
  // released, so a write landing on the deassertion edge is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  assign commit = we && armed_q && (waddr != ADDR_W'(ZERO_REG));

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (commit) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign wr_cnt    = cnt_q;
  assign array_rd1 = mem_q[raddr1];
  assign array_rd2 = mem_q[raddr2];

  regfile_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bypass1 (
    .rst        (rst),
    .re         (re1),
    .raddr      (raddr1),
    .ex_wreg    (ex_wreg_i),
    .ex_wd      (ex_wd_i),
    .ex_wdata   (ex_wdata_i),
    .mem_wreg   (mem_wreg_i),
    .mem_wd     (mem_wd_i),
    .mem_wdata  (mem_wdata_i),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .array_data (array_rd1),
    .rdata      (rdata1)
  );

  regfile_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bypass2 (
    .rst        (rst),
    .re         (re2),
    .raddr      (raddr2),
    .ex_wreg    (ex_wreg_i),
    .ex_wd      (ex_wd_i),
    .ex_wdata   (ex_wdata_i),
    .mem_wreg   (mem_wreg_i),
    .mem_wd     (mem_wd_i),
    .mem_wdata  (mem_wdata_i),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .array_data (array_rd2),
    .rdata      (rdata2)
  );

endmodule : regfile
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile
// Purpose  : Self-checking bench for regfile: a table of directed vectors
//            plus hand-written reset, deassertion-edge and counter-wrap
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic [31:0] ex_wdata_i;
  logic        mem_wreg_i;
  logic [4:0]  mem_wd_i;
  logic [31:0] mem_wdata_i;
  logic [15:0] wr_cnt;

  int n_vec;
  int n_err;

  regfile #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .re1         (re1),
    .raddr1      (raddr1),
    .rdata1      (rdata1),
    .re2         (re2),
    .raddr2      (raddr2),
    .rdata2      (rdata2),
    .ex_wreg_i   (ex_wreg_i),
    .ex_wd_i     (ex_wd_i),
    .ex_wdata_i  (ex_wdata_i),
    .mem_wreg_i  (mem_wreg_i),
    .mem_wd_i    (mem_wd_i),
    .mem_wdata_i (mem_wdata_i),
    .wr_cnt      (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic        exw;
    logic [4:0]  exd;
    logic [31:0] exdata;
    logic        mw;
    logic [4:0]  md;
    logic [31:0] mdata;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    we          = v.we;
    waddr       = v.waddr;
    wdata       = v.wdata;
    re1         = v.re1;
    raddr1      = v.raddr1;
    re2         = v.re2;
    raddr2      = v.raddr2;
    ex_wreg_i   = v.exw;
    ex_wd_i     = v.exd;
    ex_wdata_i  = v.exdata;
    mem_wreg_i  = v.mw;
    mem_wd_i    = v.md;
    mem_wdata_i = v.mdata;
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0;
    ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0;
    mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    //          we waddr  wdata          re1 ra1  re2 ra2  exw exd  exdata        mw md    mdata         exp1          exp2          cnt
    vecs[0]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 1'b1, 5'd5,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        16'd0};
    vecs[1]  = '{1'b1, 5'd3, 32'hDEADBEEF,  1'b1, 5'd3, 1'b1, 5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 16'd0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 1'b0, 5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 32'h0,        16'd1};
    vecs[3]  = '{1'b1, 5'd7, 32'h3,         1'b1, 5'd7, 1'b1, 5'd7,  1'b1, 5'd7,  32'h1,        1'b1, 5'd7, 32'h2,        32'h1,        32'h1,        16'd1};
    vecs[4]  = '{1'b1, 5'd7, 32'h3,         1'b1, 5'd7, 1'b1, 5'd7,  1'b0, 5'd7,  32'h1,        1'b1, 5'd7, 32'h2,        32'h2,        32'h2,        16'd2};
    vecs[5]  = '{1'b1, 5'd7, 32'h3,         1'b1, 5'd7, 1'b1, 5'd7,  1'b0, 5'd7,  32'h1,        1'b0, 5'd7, 32'h2,        32'h3,        32'h3,        16'd3};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 1'b1, 5'd7,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        32'h3,        32'h3,        16'd4};
    vecs[7]  = '{1'b1, 5'd0, 32'hFFFFFFFF,  1'b1, 5'd0, 1'b1, 5'd0,  1'b1, 5'd0,  32'hAAAA5555, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        16'd4};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        16'd4};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd10, 32'h11,       1'b1, 5'd9, 32'h22,       32'h22,       32'h11,       16'd4};
    vecs[10] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 1'b1, 5'd10, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        16'd4};
    vecs[11] = '{1'b1, 5'd5, 32'h12345678,  1'b1, 5'd5, 1'b1, 5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        32'h12345678, 32'hDEADBEEF, 16'd4};
    vecs[12] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 1'b1, 5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        32'h12345678, 32'hDEADBEEF, 16'd5};
    vecs[13] = '{1'b0, 5'd5, 32'hFFFFFFFF,  1'b1, 5'd5, 1'b1, 5'd5,  1'b0, 5'd5,  32'h111,      1'b0, 5'd5, 32'h222,      32'h12345678, 32'h12345678, 16'd5};

    // Reset held with a pending write and read: everything reads zero.
    rst = 1'b0;
    idle();
    we = 1'b1; waddr = 5'd3; wdata = 32'h1;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
    #1;
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_rdata2", rdata2, 32'h0);
    check("reset_wr_cnt", 32'(wr_cnt), 32'h0);
    repeat (2) @(negedge clk);
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table: inputs applied after a falling edge, checked 1 ns later.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp1);
      check($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].exp2);
      check($sformatf("vec%0d_wr_cnt", i), 32'(wr_cnt), 32'(vecs[i].exp_cnt));
    end

    // Asynchronous reset mid-cycle clears r5 and the counter at once.
    @(negedge clk);
    idle();
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd6;
    #1;
    check("pre_reset_r5", rdata1, 32'h12345678);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_r5", rdata1, 32'h0);
    check("async_reset_cnt", 32'(wr_cnt), 32'h0);
    we = 1'b1; waddr = 5'd6; wdata = 32'hABC;
    repeat (2) @(negedge clk);
    #1;
    check("reset_write_ignored_cnt", 32'(wr_cnt), 32'h0);
    check("reset_writethrough_blocked", rdata2, 32'h0);

    // Release coinciding with a rising edge while a write is presented.
    waddr = 5'd8; wdata = 32'h77; raddr2 = 5'd8;
    @(posedge clk);
    rst = 1'b1;
    @(negedge clk);
    we = 1'b0;
    #1;
    check("post_reset_r5", rdata1, 32'h0);
    check("deassert_edge_write_r8", rdata2, 32'h0);
    check("deassert_edge_cnt", 32'(wr_cnt), 32'h0);
    raddr2 = 5'd6;
    #1;
    check("reset_write_r6", rdata2, 32'h0);

    // Counter wrap: 65535 writes reach 0xFFFF, one more wraps to zero.
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = 5'd1; wdata = 32'(i);
    end
    @(negedge clk);
    we = 1'b0;
    raddr1 = 5'd1;
    #1;
    check("cnt_preload_ffff", 32'(wr_cnt), 32'h0000FFFF);
    check("last_preload_r1", rdata1, 32'd65534);
    @(negedge clk);
    we = 1'b1; waddr = 5'd2; wdata = 32'h5;
    @(negedge clk);
    we = 1'b0;
    raddr2 = 5'd2;
    #1;
    check("cnt_wrap_zero", 32'(wr_cnt), 32'h0);
    check("wrap_write_r2", rdata2, 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile
`default_nettype wire
